rams_stream_reader: RTL

- Controller placed directly in front of the 64x32 single-port, read-first block RAM; it owns that RAM's clk-domain we/addr/din pins.
- Host side offers two functions: a simple word-write path for loading or patching contents, and a command interface that streams a run of words (base, length) out as a valid/ready stream.
- The RAM's one-cycle registered read latency and downstream backpressure are absorbed by a small output buffer, so 1 word/cycle is sustained.

---
 rtl/rams_pkg.sv | 14 +
 rtl/rams_skid_fifo.sv | 38 +++
 rtl/rams_stream_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/rams_pkg.sv
// Shared types and helpers for the block-RAM stream reader.
package rams_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    // Increment an aw-bit address, wrapping from 2**aw-1 back to 0.
    function automatic logic [15:0] next_addr(input logic [15:0] a, input int aw);
        logic [15:0] mask;
        mask = 16'((32'd1 << aw) - 32'd1);
        return (a + 16'd1) & mask;
    endfunction
endpackage

// File: rtl/rams_skid_fifo.sv
// Two-entry FIFO absorbing the RAM read latency against downstream backpressure.
module rams_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic         pop_ok;

    // Upstream credit logic guarantees no push while full without a pop.
    assign pop_ok = pop & (occ != 2'd0);
    assign dout   = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop_ok)
                rp <= ~rp;
            occ <= occ + {1'b0, push} - {1'b0, pop_ok};
        end
    end
endmodule

// File: rtl/rams_stream_reader.sv
// Front-end for a single-port block RAM: host word writes plus (base,len) streaming reads.
module rams_stream_reader
    import rams_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LEN_W-1:0]  remaining;
    logic              inflight, inflight_last;
    logic [1:0]        occ;
    logic [DATA_W:0]   fifo_dout;
    logic              pop, issue, accept, drained, last_issue;

    assign pop       = out_valid & out_ready;
    assign out_valid = (occ != 2'd0);
    assign {out_last, out_data} = fifo_dout;
    assign accept    = cmd_valid & cmd_ready;

    // Issue only if the word will have a FIFO slot once it returns.
    assign issue      = (state == READ) &&
                        (({1'b0, occ} + {2'b0, inflight}) < ({2'b0, pop} + 3'd2));
    assign last_issue = issue && (remaining == LEN_W'(1));
    // Leave DRAIN on the cycle the final beat is handshaken.
    assign drained    = !inflight && ((occ == 2'd0) || (occ == 2'd1 && pop));

    always_comb begin
        state_nx  = state;
        wr_ready  = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                wr_ready  = 1'b1;
                cmd_ready = ~wr_en;
                ram_we    = wr_en;
                ram_addr  = wr_addr;
                ram_din   = wr_data;
                if (cmd_valid && !wr_en)
                    state_nx = (cmd_len == '0) ? DONE : READ;
            end
            READ: begin
                ram_addr = rd_ptr;
                if (last_issue)
                    state_nx = DRAIN;
            end
            DRAIN: if (drained) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= last_issue;
            if (accept) begin
                rd_ptr    <= cmd_base;
                remaining <= cmd_len;
            end else if (issue) begin
                rd_ptr    <= ADDR_W'(next_addr(16'(rd_ptr), ADDR_W));
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    rams_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .din  ({inflight_last, ram_dout}),
        .pop  (pop),
        .dout (fifo_dout),
        .occ  (occ)
    );
endmodule
